// File: rtl/calc_pkg.sv
// Shared definitions for the fixed-point calculator: data format, opcodes and
// the front-panel sequencer state encoding (also shown on the status LEDs).
package calc_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    ENTER_OP = 3'd2,
    RUN      = 3'd3,
    WAIT     = 3'd4,
    SHOW     = 3'd5,
    ERROR    = 3'd6
  } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioning: two-flop synchronizer, stability counter and
// rising-edge detector producing a one-cycle press pulse.
module btn_conditioner #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples have disagreed with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Front-panel sequencer: captures operands/opcode from switches, launches the
// ALU via start/done, and owns the value and error flag sent to the display.
//
//   state    | meaning
//   ENTER_A  | showing switches live, Enter captures operand A
//   ENTER_B  | showing switches live, Enter captures operand B
//   ENTER_OP | showing B, Enter captures opcode
//   RUN      | single-cycle ALU launch
//   WAIT     | waiting for alu_done under the watchdog
//   SHOW     | showing result, Enter chains it in as the next A
//   ERROR    | error pattern until Clear
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE = 500000,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic [DATA_W-1:0] sw_operand,
  input  logic [1:0]        sw_op,
  output logic              alu_start,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_err,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_err,
  output logic [2:0]        phase
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);

  state_e            state, state_n;
  logic [DATA_W-1:0] reg_a, reg_a_n;
  logic [DATA_W-1:0] reg_b, reg_b_n;
  logic [DATA_W-1:0] reg_res, reg_res_n;
  logic [1:0]        reg_op, reg_op_n;
  logic [WDW-1:0]    wd, wd_n;
  logic [DATA_W-1:0] disp_value_n;
  logic              disp_err_n;
  logic              alu_start_n;
  logic              enter_p;
  logic              clear_p;

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_enter (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_enter),
    .press   (enter_p)
  );

  btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .press   (clear_p)
  );

  always_comb begin
    state_n   = state;
    reg_a_n   = reg_a;
    reg_b_n   = reg_b;
    reg_res_n = reg_res;
    reg_op_n  = reg_op;
    wd_n      = '0;
    if (clear_p) begin
      state_n   = ENTER_A;
      reg_a_n   = '0;
      reg_b_n   = '0;
      reg_res_n = '0;
      reg_op_n  = '0;
    end else begin
      case (state)
        ENTER_A: if (enter_p) begin
          reg_a_n = sw_operand;
          state_n = ENTER_B;
        end
        ENTER_B: if (enter_p) begin
          reg_b_n = sw_operand;
          state_n = ENTER_OP;
        end
        ENTER_OP: if (enter_p) begin
          reg_op_n = sw_op;
          state_n  = RUN;
        end
        RUN: begin
          state_n = WAIT;
          wd_n    = WD_LOAD;
        end
        // watchdog reaching zero marks the last WAIT cycle a done is accepted in
        WAIT: begin
          if (alu_done) begin
            reg_res_n = alu_result;
            state_n   = alu_err ? ERROR : SHOW;
          end else if (wd == '0) begin
            state_n = ERROR;
          end else begin
            wd_n = wd - 1'b1;
          end
        end
        SHOW: if (enter_p) begin
          reg_a_n = reg_res;
          state_n = ENTER_B;
        end
        ERROR: ;
        default: state_n = ENTER_A;
      endcase
    end

    alu_start_n = (state_n == RUN);
    disp_err_n  = (state_n == ERROR);
    case (state_n)
      ENTER_A, ENTER_B:     disp_value_n = sw_operand;
      ENTER_OP, RUN, WAIT:  disp_value_n = reg_b_n;
      SHOW:                 disp_value_n = reg_res_n;
      default:              disp_value_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTER_A;
      reg_a      <= '0;
      reg_b      <= '0;
      reg_res    <= '0;
      reg_op     <= '0;
      wd         <= '0;
      alu_start  <= 1'b0;
      disp_value <= '0;
      disp_err   <= 1'b0;
    end else begin
      state      <= state_n;
      reg_a      <= reg_a_n;
      reg_b      <= reg_b_n;
      reg_res    <= reg_res_n;
      reg_op     <= reg_op_n;
      wd         <= wd_n;
      alu_start  <= alu_start_n;
      disp_value <= disp_value_n;
      disp_err   <= disp_err_n;
    end
  end

  assign alu_a  = reg_a;
  assign alu_b  = reg_b;
  assign alu_op = reg_op;
  assign phase  = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural Q9.6 ALU that
// answers three cycles after each launch unless muted.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_enter, btn_clear;
  logic [15:0] sw_operand;
  logic [1:0]  sw_op;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] disp_value;
  logic        disp_err;
  logic [2:0]  phase;

  always #5 clk = ~clk;

  calc_sequencer #(.DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_enter  (btn_enter),
    .btn_clear  (btn_clear),
    .sw_operand (sw_operand),
    .sw_op      (sw_op),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .phase      (phase)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Q9.6 reference arithmetic with saturation-free overflow detection
  function automatic void alu_fn(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] op,
                                 output logic [15:0] r, output logic e);
    logic signed [31:0] sa, sb, t;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    e  = 1'b0;
    t  = 0;
    case (op)
      2'b00: t = sa + sb;
      2'b01: t = sa - sb;
      2'b10: t = (sa * sb) >>> 6;
      default: begin
        if (sb == 0) begin
          e = 1'b1;
        end else begin
          t = (sa * 64) / sb;
        end
      end
    endcase
    if (t > 32767 || t < -32768) e = 1'b1;
    r = t[15:0];
  endfunction

  // ALU model
  bit          alu_mute = 1'b0;
  int          inj_seq = 0;
  logic [15:0] inj_res = '0;
  logic        inj_err_v = 1'b0;
  int          start_cnt = 0;
  logic [15:0] cap_a = '0, cap_b = '0;
  logic [1:0]  cap_op = '0;

  initial begin
    int          pend;
    int          inj_seen;
    logic [15:0] m_res;
    logic        m_err;
    pend = 0; inj_seen = 0; m_res = '0; m_err = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      alu_done = 1'b0;
      alu_err  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          alu_done = 1'b1; alu_result = m_res; alu_err = m_err;
        end
      end
      if (inj_seq != inj_seen) begin
        inj_seen = inj_seq;
        alu_done = 1'b1; alu_result = inj_res; alu_err = inj_err_v;
      end
      if (alu_start === 1'b1) begin
        start_cnt++;
        cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
        if (!alu_mute) begin
          alu_fn(alu_a, alu_b, alu_op, m_res, m_err);
          pend = 3;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global time limit: summary not reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic e, input logic c);
    btn_enter = e; btn_clear = c;
    tick(10);
    btn_enter = 1'b0; btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget, input string name);
    int n = 0;
    while (phase !== p && n < budget) begin tick(); n++; end
    chk(name, {29'd0, phase}, {29'd0, p});
  endtask

  task automatic run_calc(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    sw_operand = a; press(1'b1, 1'b0);
    sw_operand = b; press(1'b1, 1'b0);
    sw_op = op;     press(1'b1, 1'b0);
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vt [6];

  initial begin
    int          n, s0;
    bit          have_acc;
    logic [15:0] acc, ea, b, r;
    logic [1:0]  op;
    logic        e;

    vt[0] = '{16'h0060, 16'h0090, 2'b00, 16'h00F0, 1'b0};
    vt[1] = '{16'h00F0, 16'h0040, 2'b01, 16'h00B0, 1'b0};
    vt[2] = '{16'h0080, 16'h00C0, 2'b10, 16'h0180, 1'b0};
    vt[3] = '{16'h0180, 16'h0080, 2'b11, 16'h00C0, 1'b0};
    vt[4] = '{16'h0100, 16'h0000, 2'b11, 16'h0000, 1'b1};
    vt[5] = '{16'h7FC0, 16'h0040, 2'b00, 16'h0000, 1'b1};

    // reset values, checked before any clock edge
    rst = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0;
    sw_operand = 16'h1234; sw_op = 2'b00;
    #3;
    chk("reset phase", {29'd0, phase}, 0);
    chk("reset alu_start", {31'd0, alu_start}, 0);
    chk("reset alu_a", {16'd0, alu_a}, 0);
    chk("reset alu_b", {16'd0, alu_b}, 0);
    chk("reset alu_op", {30'd0, alu_op}, 0);
    chk("reset disp_value", {16'd0, disp_value}, 0);
    chk("reset disp_err", {31'd0, disp_err}, 0);
    #20 rst = 1'b0;
    tick(3);
    chk("enter_a live display", {16'd0, disp_value}, 32'h1234);

    // button latency: raw edge to state change = 2 + DEB + 1 + 1 cycles
    sw_operand = 16'h0060;
    btn_enter = 1'b1;
    n = 0;
    do begin tick(); n++; end while (phase === 3'd0 && n < 30);
    chk("enter latency cycles", n, 2 + DEB + 2);
    chk("capture A", {16'd0, alu_a}, 32'h0060);
    btn_enter = 1'b0; tick(10);
    sw_operand = 16'h0090; press(1'b1, 1'b0);
    chk("phase enter_op", {29'd0, phase}, 2);
    sw_operand = 16'h5555; tick(2);
    chk("enter_op shows B", {16'd0, disp_value}, 32'h0090);
    s0 = start_cnt;
    sw_op = 2'b00; press(1'b1, 1'b0);
    chk("add start count", start_cnt - s0, 1);
    chk("add alu_a", {16'd0, cap_a}, 32'h0060);
    chk("add alu_b", {16'd0, cap_b}, 32'h0090);
    chk("add phase show", {29'd0, phase}, 5);
    chk("add disp_value", {16'd0, disp_value}, 32'h00F0);

    // spurious done in SHOW
    inj_res = 16'h1111; inj_err_v = 1'b1; inj_seq++;
    tick(4);
    chk("spurious done phase", {29'd0, phase}, 5);
    chk("spurious done disp", {16'd0, disp_value}, 32'h00F0);

    // chained calculation
    s0 = start_cnt;
    press(1'b1, 1'b0);
    chk("chain phase enter_b", {29'd0, phase}, 1);
    chk("chain A from result", {16'd0, alu_a}, 32'h00F0);
    sw_operand = 16'h0040; press(1'b1, 1'b0);
    sw_op = 2'b01;        press(1'b1, 1'b0);
    chk("chain start count", start_cnt - s0, 1);
    chk("chain alu_a", {16'd0, cap_a}, 32'h00F0);
    chk("chain alu_b", {16'd0, cap_b}, 32'h0040);
    chk("chain alu_op", {30'd0, cap_op}, 1);
    chk("chain disp_value", {16'd0, disp_value}, 32'h00B0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      press(1'b0, 1'b1);
      s0 = start_cnt;
      run_calc(vt[i].a, vt[i].b, vt[i].op);
      chk("vec start count", start_cnt - s0, 1);
      chk("vec alu_a", {16'd0, cap_a}, {16'd0, vt[i].a});
      chk("vec alu_b", {16'd0, cap_b}, {16'd0, vt[i].b});
      chk("vec alu_op", {30'd0, cap_op}, {30'd0, vt[i].op});
      chk("vec phase", {29'd0, phase}, vt[i].err ? 32'd6 : 32'd5);
      chk("vec disp_value", {16'd0, disp_value}, {16'd0, vt[i].res});
      chk("vec disp_err", {31'd0, disp_err}, {31'd0, vt[i].err});
    end

    // bounce then steady press: exactly one capture
    press(1'b0, 1'b1);
    sw_operand = 16'h0123;
    for (int i = 0; i < 10; i++) begin btn_enter = ~btn_enter; tick(2); end
    btn_enter = 1'b1; tick(10);
    btn_enter = 1'b0; tick(10);
    chk("bounce single capture phase", {29'd0, phase}, 1);
    chk("bounce captured A", {16'd0, alu_a}, 32'h0123);
    sw_operand = 16'h0777;
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(15);
    chk("glitch ignored phase", {29'd0, phase}, 1);
    chk("glitch ignored B", {16'd0, alu_b}, 0);

    // error path: enter dropped, clear recovers
    press(1'b0, 1'b1);
    run_calc(16'h0100, 16'h0000, 2'b11);
    chk("div0 phase error", {29'd0, phase}, 6);
    chk("div0 disp_err", {31'd0, disp_err}, 1);
    chk("div0 disp_value", {16'd0, disp_value}, 0);
    press(1'b1, 1'b0);
    chk("enter ignored in error", {29'd0, phase}, 6);
    press(1'b0, 1'b1);
    chk("clear from error phase", {29'd0, phase}, 0);
    chk("clear zeroes A", {16'd0, alu_a}, 0);
    chk("clear zeroes B", {16'd0, alu_b}, 0);
    chk("clear zeroes op", {30'd0, alu_op}, 0);
    chk("clear disp_err", {31'd0, disp_err}, 0);

    // watchdog timeout
    alu_mute = 1'b1;
    sw_operand = 16'h0010; press(1'b1, 1'b0);
    sw_operand = 16'h0020; press(1'b1, 1'b0);
    sw_op = 2'b10; btn_enter = 1'b1;
    wait_phase(3'd4, 30, "reach wait");
    n = 0;
    while (phase === 3'd4 && n < 20) begin tick(); n++; end
    chk("timeout wait cycles", n, TMO);
    chk("timeout phase error", {29'd0, phase}, 6);
    chk("timeout disp_err", {31'd0, disp_err}, 1);
    btn_enter = 1'b0; tick(10);
    press(1'b0, 1'b1);
    s0 = start_cnt;
    inj_res = 16'h2222; inj_err_v = 1'b0; inj_seq++;
    tick(4);
    chk("late done after clear phase", {29'd0, phase}, 0);

    // clear during WAIT abandons; a late done is ignored
    sw_operand = 16'h0030; press(1'b1, 1'b0);
    sw_operand = 16'h0040; press(1'b1, 1'b0);
    sw_op = 2'b00; btn_enter = 1'b1;
    tick(3); btn_clear = 1'b1;
    wait_phase(3'd4, 30, "reach wait before clear");
    wait_phase(3'd0, 20, "clear during wait");
    btn_enter = 1'b0; btn_clear = 1'b0; tick(10);
    inj_res = 16'h3333; inj_seq++;
    tick(4);
    chk("abandoned done phase", {29'd0, phase}, 0);
    chk("abandoned A zeroed", {16'd0, alu_a}, 0);
    chk("abandoned start count", start_cnt - s0, 1);

    // enter and clear in the same cycle: clear wins
    sw_operand = 16'h0050; press(1'b1, 1'b0);
    chk("priority setup phase", {29'd0, phase}, 1);
    press(1'b1, 1'b1);
    chk("clear beats enter phase", {29'd0, phase}, 0);
    chk("clear beats enter A", {16'd0, alu_a}, 0);

    // asynchronous reset mid-WAIT
    sw_operand = 16'h0AAA; press(1'b1, 1'b0);
    sw_operand = 16'h0BBB; press(1'b1, 1'b0);
    sw_op = 2'b11; btn_enter = 1'b1;
    wait_phase(3'd4, 30, "reach wait before rst");
    #2 rst = 1'b1;
    #1;
    chk("async rst phase", {29'd0, phase}, 0);
    chk("async rst alu_a", {16'd0, alu_a}, 0);
    chk("async rst alu_b", {16'd0, alu_b}, 0);
    chk("async rst alu_op", {30'd0, alu_op}, 0);
    chk("async rst disp_value", {16'd0, disp_value}, 0);
    chk("async rst disp_err", {31'd0, disp_err}, 0);
    chk("async rst alu_start", {31'd0, alu_start}, 0);
    btn_enter = 1'b0;
    tick(3); rst = 1'b0; tick(10);

    // randomized flows against the reference model
    alu_mute = 1'b0;
    have_acc = 1'b0;
    acc = '0;
    for (int it = 0; it < 14; it++) begin
      if (have_acc && $urandom_range(0, 1) == 1) begin
        ea = acc;
        press(1'b1, 1'b0);
      end else begin
        press(1'b0, 1'b1);
        ea = 16'($urandom);
        if ($urandom_range(0, 3) != 0) ea = {{5{ea[10]}}, ea[10:0]};
        sw_operand = ea;
        press(1'b1, 1'b0);
      end
      b = 16'($urandom);
      if ($urandom_range(0, 3) != 0) b = {{5{b[10]}}, b[10:0]};
      if ($urandom_range(0, 7) == 0) b = '0;
      op = 2'($urandom_range(0, 3));
      sw_operand = b; press(1'b1, 1'b0);
      s0 = start_cnt;
      sw_op = op; press(1'b1, 1'b0);
      alu_fn(ea, b, op, r, e);
      chk("rand start count", start_cnt - s0, 1);
      chk("rand alu_a", {16'd0, cap_a}, {16'd0, ea});
      chk("rand alu_b", {16'd0, cap_b}, {16'd0, b});
      chk("rand alu_op", {30'd0, cap_op}, {30'd0, op});
      chk("rand phase", {29'd0, phase}, e ? 32'd6 : 32'd5);
      chk("rand disp_value", {16'd0, disp_value}, e ? 32'd0 : {16'd0, r});
      chk("rand disp_err", {31'd0, disp_err}, {31'd0, e});
      have_acc = !e;
      acc = r;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
